// File: rtl/mem_access_if.sv
// Pipeline-side load/store bus of the memory access unit.
interface mem_access_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              stall;
    logic              err;

    modport master (
        output addr, write_data, mem_write, mem_read,
        input  read_data, read_valid, stall, err
    );
    modport slave (
        input  addr, write_data, mem_write, mem_read,
        output read_data, read_valid, stall, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: data RAM, FFT/crypto register windows, start handshake with stall.
// Optional macro ACC_TIMEOUT_EN bounds the start wait to TIMEOUT_CYC stall cycles.
module mem_access_unit #(
    parameter int                DATA_W      = 19,
    parameter int                ADDR_W      = 19,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] FFT_BASE    = 19'h7F000,
    parameter logic [ADDR_W-1:0] CRYPTO_BASE = 19'h06000,
    parameter int                WIN_SPAN    = 16,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.slave       bus,
    output logic [DATA_W-1:0] fft_key,
    output logic              fft_start,
    input  logic              fft_busy,
    input  logic              fft_done,
    output logic [DATA_W-1:0] crypto_key,
    output logic              crypto_start,
    input  logic              crypto_busy,
    input  logic              crypto_done
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_KEY  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_CTRL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(2);

    typedef enum logic [1:0] {IDLE, WAIT_FFT, WAIT_CRYPTO} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] fft_off, cry_off;
    logic              in_fft, in_cry, in_ram, oor;
    logic              idle, wr, rd, both;
    logic              fft_go, cry_go, wait_busy;
    logic              fft_sticky, cry_sticky;
    logic [DATA_W-1:0] win_rdata;
    logic [DATA_W-1:0] read_data_q;
    logic              read_valid_q, err_q;
`ifdef ACC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_comb begin
        fft_off   = bus.addr - FFT_BASE;
        cry_off   = bus.addr - CRYPTO_BASE;
        in_fft    = (bus.addr >= FFT_BASE) && (fft_off < ADDR_W'(WIN_SPAN));
        in_cry    = (bus.addr >= CRYPTO_BASE) && (cry_off < ADDR_W'(WIN_SPAN));
        in_ram    = !in_fft && !in_cry && (bus.addr < ADDR_W'(DEPTH));
        oor       = !(in_fft || in_cry || in_ram);
        idle      = (state == IDLE);
        // Requests are only accepted while idle; a stalled pipeline replays nothing.
        wr        = idle && bus.mem_write;
        rd        = idle && bus.mem_read && !bus.mem_write;
        both      = idle && bus.mem_write && bus.mem_read;
        fft_go    = wr && in_fft && (fft_off == OFF_CTRL) && bus.write_data[0];
        cry_go    = wr && in_cry && (cry_off == OFF_CTRL) && bus.write_data[0];
        wait_busy = (state == WAIT_FFT) ? fft_busy : crypto_busy;
        win_rdata = '0;
        if (in_fft) begin
            if (fft_off == OFF_KEY)  win_rdata = fft_key;
            if (fft_off == OFF_STAT) win_rdata = DATA_W'({fft_busy, fft_sticky});
        end else if (in_cry) begin
            if (cry_off == OFF_KEY)  win_rdata = crypto_key;
            if (cry_off == OFF_STAT) win_rdata = DATA_W'({crypto_busy, cry_sticky});
        end
    end

    // Stall rises in the same cycle a start hits a busy accelerator.
    assign bus.stall      = !idle || (fft_go && fft_busy) || (cry_go && crypto_busy);
    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.err        = err_q;

    always_ff @(posedge clk) begin
        if (!rst && wr && in_ram) mem[bus.addr[IDX_W-1:0]] <= bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            err_q        <= 1'b0;
            fft_key      <= '0;
            crypto_key   <= '0;
            fft_start    <= 1'b0;
            crypto_start <= 1'b0;
            fft_sticky   <= 1'b0;
            cry_sticky   <= 1'b0;
`ifdef ACC_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            read_valid_q <= rd;
            err_q        <= both || ((wr || rd) && oor);
            fft_start    <= 1'b0;
            crypto_start <= 1'b0;
            if (rd) read_data_q <= in_ram ? mem[bus.addr[IDX_W-1:0]] : win_rdata;
            // A done pulse wins over a coincident STATUS read clear.
            fft_sticky <= fft_done || (fft_sticky && !(rd && in_fft && fft_off == OFF_STAT));
            cry_sticky <= crypto_done || (cry_sticky && !(rd && in_cry && cry_off == OFF_STAT));
            if (wr && in_fft && fft_off == OFF_KEY) fft_key    <= bus.write_data;
            if (wr && in_cry && cry_off == OFF_KEY) crypto_key <= bus.write_data;
            case (state)
                IDLE: begin
`ifdef ACC_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (fft_go) begin
                        if (fft_busy) state <= WAIT_FFT;
                        else          fft_start <= 1'b1;
                    end
                    if (cry_go) begin
                        if (crypto_busy) state <= WAIT_CRYPTO;
                        else             crypto_start <= 1'b1;
                    end
                end
                WAIT_FFT, WAIT_CRYPTO: begin
                    if (!wait_busy) begin
                        if (state == WAIT_FFT) fft_start    <= 1'b1;
                        else                   crypto_start <= 1'b1;
                        state <= IDLE;
                    end
`ifdef ACC_TIMEOUT_EN
                    // Entry cycle counts as the first stall cycle.
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 2)) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline MEM stage. Owns the data RAM and memory-mapped register windows for the FFT and crypto accelerators.
- Adds registered reads with a valid flag, accelerator start handshakes with pipeline stall, sticky done status, and range checking.
- Sits between EX/MEM and MEM/WB; accelerators attach directly to its key/start/busy/done pins.

Parameters:
DATA_W, 19, data/key width
ADDR_W, 19, byte-free word address width
DEPTH, 1024, data RAM words (power of two)
FFT_BASE, 19'h7F000, FFT window base
CRYPTO_BASE, 19'h06000, crypto window base
WIN_SPAN, 16, words per accelerator window
TIMEOUT_CYC, 256, stall limit (used only with ACC_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  ADDR_W  access address
write_data  in  DATA_W  store data
mem_write  in  1  store request
mem_read  in  1  load request
read_data  out  DATA_W  load result (registered)
read_valid  out  1  read_data valid this cycle
stall  out  1  hold upstream pipeline
err  out  1  one-cycle access error pulse
fft_key  out  DATA_W  FFT key/config register
fft_start  out  1  one-cycle FFT start pulse
fft_busy  in  1  FFT running
fft_done  in  1  FFT completion pulse
crypto_key  out  DATA_W  crypto key register
crypto_start  out  1  one-cycle crypto start pulse
crypto_busy  in  1  crypto running
crypto_done  in  1  crypto completion pulse

Behaviour:
- Decode: FFT window when FFT_BASE <= addr < FFT_BASE+WIN_SPAN; crypto likewise. Otherwise RAM if addr < DEPTH. Anything else is out-of-range.
- Window offsets:
  - 0: KEY (R/W)
  - 1: CTRL (write bit0=1 requests start; reads return 0)
  - 2: STATUS (read {busy,done_sticky} in bits[1:0]; writes ignored)
  - Other offsets: read 0, writes ignored, no err.
- Load: accepted in cycle N. read_data and read_valid are driven in N+1. read_valid is high for exactly one cycle. read_data holds its last value otherwise. RAM read is synchronous.
- Store: takes effect at the accepting clock edge. A load of the same address in N+1 returns the new data.
- mem_write && mem_read in the same cycle: write performed, read dropped, err pulses in N+1.
- Out-of-range access: write ignored, read returns 0 with read_valid, err pulses in N+1.
- Start handshake FSM states:
  - IDLE: CTRL write with bit0=1 and the target not busy pulses *_start in N+1. CTRL write with the target busy moves to WAIT_<acc>; stall rises combinationally in cycle N.
  - WAIT_<acc>: stall=1; upstream holds inputs; other requests ignored. On the first cycle busy=0, pulse *_start next cycle, drop stall, return to IDLE.
- done_sticky: set by *_done and cleared by a STATUS read. A *_done in the same cycle as a STATUS read leaves it set; the read returns the pre-edge value.
- Keys update on KEY writes only. KEY writes during WAIT do not occur because stall holds the pipeline.
- Reset: read_data=0, read_valid=0, stall=0, err=0, keys=0, starts=0, done_sticky=0, FSM=IDLE. RAM contents not reset. Reset during WAIT aborts the pending start; no start pulse.

Optional Feature:
ACC_TIMEOUT_EN:
- Defined: a counter runs in WAIT. After TIMEOUT_CYC stall cycles with busy still high: no start, err pulses one cycle, stall drops, FSM returns to IDLE.
- Undefined: WAIT persists until busy falls. No counter is synthesised.

Test Plan:
- Write 123 to 0x00100, then read 0x00100 next cycle -> read_valid=1 with read_data=123 one cycle after the read.
- Write 138 to 0x7F000 -> fft_key=138 after the edge. Write 255 to 0x06000 -> crypto_key=255. Read 0x7F000 -> 138.
- fft_busy=0, write 1 to 0x7F001 -> fft_start high exactly one cycle, stall never asserts.
- crypto_busy=1, write 1 to 0x06001, drop busy 5 cycles later -> stall high 6 cycles, crypto_start pulses once after busy drops.
- Pulse fft_done, read 0x7F002 -> bits[1:0]=01. Second read -> 00. done coincident with read -> stays 1.
- Read 0x00500 (DEPTH 1024) -> read_data=0 and err pulse. With ACC_TIMEOUT_EN and busy stuck -> err after 256 stall cycles, no start.
